bo_datapath: RTL
================

# bo_datapath

Operational block (datapath) driven by the `BC` control-strobe FSM. It is the receiving end of the LX/LS/LH/H control interface. It holds the X, H and S registers, routes H through a 2:1 mux, and forms the sum S = H + X. It reports results, an overflow flag and a load count back to the system.

## Interface

Parameters:
- `W`, 8: datapath width of X, H and S.
- `CW`, 4: width of the S-load counter.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `lx`  in  1: load X strobe.
- `ls`  in  1: load S strobe.
- `lh`  in  1: load H strobe.
- `h_sel`  in  1: H-mux select (`1` = X, `0` = S). Driven by the controller's `H` line.
- `ovf_clr`  in  1: clears the sticky overflow flag.
- `x_in`  in  W: operand bus.
- `x_out`  out  W: current X register.
- `h_out`  out  W: current H register.
- `s_out`  out  W: current S register.
- `s_valid`  out  1: one-cycle pulse, high in the cycle after an S load.
- `carry`  out  1: carry-out of the most recent S load.
- `ovf`  out  1: sticky; set by any S load with carry.
- `ls_cnt`  out  CW: number of S loads since reset, modulo 2^CW.

## Operation

- Mux: `M = h_sel ? X : S`, combinational, using current register values.
- Adder: `{c, sum} = H + X`, zero-extended to W+1 bits; `sum` is the low W bits.
- On each rising edge of `clk` with `rst = 0`, in parallel:
  - `lx`: `X <= x_in`.
  - `lh`: `H <= M`.
  - `ls`: `S <= sum`, `carry <= c`, `ls_cnt <= ls_cnt + 1` (wraps 2^CW−1 → 0).
  - `s_valid <= ls`.
- Overflow flag:
  - If `ovf_clr = 1`, `ovf <= ls & c`. A carry arriving in the same cycle wins over the clear.
  - Otherwise, `ovf <= ovf | (ls & c)`.
- Strobes are independent; any combination may be active in the same cycle. Every register samples pre-edge values:
  - `lx` together with `lh` and `h_sel = 1`: H gets the old X.
  - `lh` together with `ls`: S uses the old H.
  - `ls` together with `lh` and `h_sel = 0`: H gets the old S.
- A register whose strobe is low holds its value. `carry` holds between S loads.
- Reset, including mid-sequence: X, H, S, `carry`, `ovf`, `ls_cnt` and `s_valid` all go to 0. Reset overrides every strobe in the same cycle.
- No internal FSM beyond the register set. Sequencing belongs to the controller. The datapath must behave correctly for any strobe pattern, including every `BC` state pattern.

## Timing

- All outputs are registered. No combinational path from any input to any output.
- Load latency: a value is visible on its output 1 cycle after the strobe edge.
- `s_valid` rises in the cycle after the `ls` edge, together with the new `s_out`, `carry`, `ls_cnt` and `ovf`.
- Back-to-back `ls` keeps `s_valid` high continuously; each cycle reflects that cycle's load.
- Critical path: X/H register → W-bit adder → S register. Must close at the system clock without pipelining.

## Structure

- Shared package `bc_bo_pkg`:
  - `H_SEL_X = 1'b1`, `H_SEL_S = 1'b0`.
  - Default `W` and `CW`.
  - A strobe-bundle typedef `{lx, ls, lh, h}`, shared with `BC` so both ends agree on the interface.
- One sub-module, `bo_adder`: parameterised W-bit adder returning `{carry, sum}`. Everything else stays flat in `bo_datapath`.

## Test plan

1. Reset: drive all strobes high during `rst = 1` → next cycle all outputs are 0 and `s_valid = 0`.
2. Basic sum (W = 8):
   - `x_in = 5`, `lx` → X = 5.
   - `lh`, `h_sel = 1` → H = 5.
   - `ls` → S = 10, `carry = 0`, `s_valid` pulses once, `ls_cnt = 1`.
3. Feedback:
   - From scenario 2, `lh`, `h_sel = 0` → H = 10.
   - `ls` → S = 15, `ls_cnt = 2`.
4. Overflow:
   - X = 200, H = 100, `ls` → S = 44, `carry = 1`, `ovf = 1`.
   - Then X = 1, H = 1, `ls` → `carry = 0`, `ovf` stays 1.
   - `ovf_clr` alone → `ovf = 0`.
   - `ovf_clr` together with a carrying `ls` → `ovf = 1`.
5. Simultaneous strobes:
   - Start at X = 3, H = 7, S = 0.
   - Same cycle: `x_in = 9`, `lx`, `lh`, `ls`, `h_sel = 1`.
   - Result: X = 9, H = 3, S = 10.
6. Counter wrap and mid-operation reset, CW = 4:
   - 16 `ls` pulses → `ls_cnt` returns to 0.
   - Assert `rst` during an `ls` cycle → S = 0 and no `s_valid` pulse.

Source files
------------

// File: rtl/bc_bo_pkg.sv
//------------------------------------------------------------------------------
// Module  : bc_bo_pkg
// Brief   : Definitions shared by the BC controller and the bo_datapath.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package bc_bo_pkg;

    localparam logic H_SEL_X = 1'b1;
    localparam logic H_SEL_S = 1'b0;

    localparam int W_DEF  = 8;
    localparam int CW_DEF = 4;

    // The strobe bundle that BC drives into the datapath each cycle.
    typedef struct packed {
        logic lx;
        logic ls;
        logic lh;
        logic h;
    } bc_strobe_t;

endpackage : bc_bo_pkg

`default_nettype wire

// File: rtl/bo_datapath_if.sv
//------------------------------------------------------------------------------
// Module  : bo_datapath_if
// Brief   : Control strobes, operand bus and result bus between BC and the datapath.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface bo_datapath_if
    import bc_bo_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int CW = CW_DEF
) ();

    logic          lx;
    logic          ls;
    logic          lh;
    logic          h_sel;
    logic          ovf_clr;
    logic [W-1:0]  x_in;
    logic [W-1:0]  x_out;
    logic [W-1:0]  h_out;
    logic [W-1:0]  s_out;
    logic          s_valid;
    logic          carry;
    logic          ovf;
    logic [CW-1:0] ls_cnt;

    modport master (
        output lx, ls, lh, h_sel, ovf_clr, x_in,
        input  x_out, h_out, s_out, s_valid, carry, ovf, ls_cnt
    );

    modport slave (
        input  lx, ls, lh, h_sel, ovf_clr, x_in,
        output x_out, h_out, s_out, s_valid, carry, ovf, ls_cnt
    );

endinterface : bo_datapath_if

`default_nettype wire

// File: rtl/bo_adder.sv
//------------------------------------------------------------------------------
// Module  : bo_adder
// Brief   : Unsigned W-bit adder returning {carry, sum}.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bo_adder #(
    parameter int W = 8
) (
    input  wire logic [W-1:0] i_a,
    input  wire logic [W-1:0] i_b,
    output logic      [W:0]   o_sum
);

    assign o_sum = {1'b0, i_a} + {1'b0, i_b};

endmodule : bo_adder

`default_nettype wire

// File: rtl/bo_datapath.sv
//------------------------------------------------------------------------------
// Module  : bo_datapath
// Brief   : X/H/S register set with H mux and S = H + X adder, driven by BC strobes.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bo_datapath
    import bc_bo_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int CW = CW_DEF
) (
    input  wire logic    clk,
    input  wire logic    rst,
    bo_datapath_if.slave bus
);

    bc_strobe_t    w_strb;
    logic [W-1:0]  w_mux;
    logic [W:0]    w_add;

    logic [W-1:0]  r_x;
    logic [W-1:0]  r_h;
    logic [W-1:0]  r_s;
    logic          r_carry;
    logic          r_ovf;
    logic          r_s_valid;
    logic [CW-1:0] r_cnt;

    assign w_strb = '{lx: bus.lx, ls: bus.ls, lh: bus.lh, h: bus.h_sel};

    always_comb begin
        w_mux = r_s;
        case (w_strb.h)
            H_SEL_X: w_mux = r_x;
            H_SEL_S: w_mux = r_s;
            default: w_mux = r_s;
        endcase
    end

    bo_adder #(
        .W (W)
    ) u_adder (
        .i_a   (r_h),
        .i_b   (r_x),
        .o_sum (w_add)
    );

    // All registers sample pre-edge values, so any strobe combination is safe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x       <= '0;
            r_h       <= '0;
            r_s       <= '0;
            r_carry   <= 1'b0;
            r_ovf     <= 1'b0;
            r_s_valid <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (w_strb.lx) r_x <= bus.x_in;
            if (w_strb.lh) r_h <= w_mux;
            if (w_strb.ls) begin
                r_s     <= w_add[W-1:0];
                r_carry <= w_add[W];
                r_cnt   <= r_cnt + CW'(1);
            end
            r_s_valid <= w_strb.ls;
            // A carry in the clearing cycle still sets the flag.
            r_ovf     <= (bus.ovf_clr ? 1'b0 : r_ovf) | (w_strb.ls & w_add[W]);
        end
    end

    assign bus.x_out   = r_x;
    assign bus.h_out   = r_h;
    assign bus.s_out   = r_s;
    assign bus.s_valid = r_s_valid;
    assign bus.carry   = r_carry;
    assign bus.ovf     = r_ovf;
    assign bus.ls_cnt  = r_cnt;

endmodule : bo_datapath

`default_nettype wire
